// File: rtl/matrix_multiplier.sv
// Two-stage unsigned 4x4 matrix by 4x1 vector multiplier (y = A*x).
// Stage 1 registers the 16 exact products; stage 2 registers the four row sums.
module matrix_multiplier #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [N-1:0]   a1,
  input  logic [N-1:0]   a2,
  input  logic [N-1:0]   a3,
  input  logic [N-1:0]   a4,
  input  logic [N-1:0]   a5,
  input  logic [N-1:0]   a6,
  input  logic [N-1:0]   a7,
  input  logic [N-1:0]   a8,
  input  logic [N-1:0]   a9,
  input  logic [N-1:0]   a10,
  input  logic [N-1:0]   a11,
  input  logic [N-1:0]   a12,
  input  logic [N-1:0]   a13,
  input  logic [N-1:0]   a14,
  input  logic [N-1:0]   a15,
  input  logic [N-1:0]   a16,
  input  logic [N-1:0]   x1,
  input  logic [N-1:0]   x2,
  input  logic [N-1:0]   x3,
  input  logic [N-1:0]   x4,
  output logic           out_valid,
  output logic [2*N+2:0] y1,
  output logic [2*N+2:0] y2,
  output logic [2*N+2:0] y3,
  output logic [2*N+2:0] y4
);

  localparam int PW = 2 * N;
  localparam int YW = 2 * N + 3;

  logic [N-1:0]  a_vec [16];
  logic [N-1:0]  x_vec [4];
  logic [PW-1:0] prod_c [16];
  logic [PW-1:0] prod_p1 [16];
  logic          vld_p1;
  logic [YW-1:0] sum_c [4];
  logic [YW-1:0] y_p2 [4];
  logic          vld_p2;

  // Operands are zero-extended before multiplying so the product is exact.
  function automatic logic [PW-1:0] mul_exact(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [PW-1:0] ae;
    logic [PW-1:0] be;
    ae = PW'(a);
    be = PW'(b);
    return ae * be;
  endfunction

  // Four 2N-bit terms need 2N+2 bits; the extra top bit stays zero.
  function automatic logic [YW-1:0] row_sum(input logic [PW-1:0] p0, input logic [PW-1:0] p1,
                                            input logic [PW-1:0] p2, input logic [PW-1:0] p3);
    return YW'(p0) + YW'(p1) + YW'(p2) + YW'(p3);
  endfunction

  assign a_vec = '{a1, a2, a3, a4, a5, a6, a7, a8, a9, a10, a11, a12, a13, a14, a15, a16};
  assign x_vec = '{x1, x2, x3, x4};

  for (genvar g = 0; g < 16; g++) begin : g_prod
    assign prod_c[g] = mul_exact(a_vec[g], x_vec[g % 4]);
  end

  // Stage 0 -> 1: product registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      prod_p1 <= '{default: '0};
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) prod_p1 <= prod_c;
    end
  end

  for (genvar r = 0; r < 4; r++) begin : g_row
    assign sum_c[r] = row_sum(prod_p1[4*r], prod_p1[4*r+1], prod_p1[4*r+2], prod_p1[4*r+3]);
  end

  // Stage 1 -> 2: row-sum output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      y_p2   <= '{default: '0};
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) y_p2 <= sum_c;
    end
  end

  assign out_valid = vld_p2;
  assign y1 = y_p2[0];
  assign y2 = y_p2[1];
  assign y3 = y_p2[2];
  assign y4 = y_p2[3];

endmodule

// File: tb/tb_matrix_multiplier.sv
// Directed bench for matrix_multiplier (N=16): latency, hold, throughput, width and reset.
module tb_matrix_multiplier;

  localparam int N  = 16;
  localparam int YW = 2 * N + 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [N-1:0]  a [16];
  logic [N-1:0]  x [4];
  logic          out_valid;
  logic [YW-1:0] y_o [4];

  int checks = 0;
  int errors = 0;

  matrix_multiplier #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a1(a[0]), .a2(a[1]), .a3(a[2]), .a4(a[3]),
    .a5(a[4]), .a6(a[5]), .a7(a[6]), .a8(a[7]),
    .a9(a[8]), .a10(a[9]), .a11(a[10]), .a12(a[11]),
    .a13(a[12]), .a14(a[13]), .a15(a[14]), .a16(a[15]),
    .x1(x[0]), .x2(x[1]), .x3(x[2]), .x4(x[3]),
    .out_valid(out_valid),
    .y1(y_o[0]), .y2(y_o[1]), .y3(y_o[2]), .y4(y_o[3])
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_identity();
    for (int i = 0; i < 16; i++) a[i] = '0;
    a[0] = 1; a[5] = 1; a[10] = 1; a[15] = 1;
    x[0] = 1; x[1] = 2; x[2] = 3; x[3] = 4;
  endtask

  task automatic set_anti();
    for (int i = 0; i < 16; i++) a[i] = '0;
    a[3] = 1; a[6] = 1; a[9] = 1; a[12] = 1;
    x[0] = 1; x[1] = 2; x[2] = 3; x[3] = 4;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    set_identity();
    repeat (3) step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %0b want 0", out_valid);
    end
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (y_o[r] !== '0) begin
        errors++; $display("FAIL reset_y%0d got %0h want 0", r + 1, y_o[r]);
      end
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    repeat (3) step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release_valid got %0b want 0", out_valid);
    end
  endtask

  task automatic test_identity();
    logic [YW-1:0] exp_y [4];
    exp_y = '{35'd1, 35'd2, 35'd3, 35'd4};
    set_identity();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL ident_early_valid got %0b want 0", out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL ident_valid got %0b want 1", out_valid);
    end
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (y_o[r] !== exp_y[r]) begin
        errors++; $display("FAIL ident_y%0d got %0d want %0d", r + 1, y_o[r], exp_y[r]);
      end
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL ident_after_valid got %0b want 0", out_valid);
    end
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (y_o[r] !== exp_y[r]) begin
        errors++; $display("FAIL ident_hold_y%0d got %0d want %0d", r + 1, y_o[r], exp_y[r]);
      end
    end
  endtask

  task automatic test_anti_diag(input string tag);
    logic [YW-1:0] exp_y [4];
    exp_y = '{35'd4, 35'd3, 35'd2, 35'd1};
    set_anti();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL %s_early_valid got %0b want 0", tag, out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL %s_valid got %0b want 1", tag, out_valid);
    end
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (y_o[r] !== exp_y[r]) begin
        errors++; $display("FAIL %s_y%0d got %0d want %0d", tag, r + 1, y_o[r], exp_y[r]);
      end
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [YW-1:0] exp1 [4];
    logic [YW-1:0] exp2 [4];
    exp1 = '{35'd1, 35'd2, 35'd3, 35'd4};
    exp2 = '{35'd25, 35'd20, 35'd15, 35'd30};
    set_identity();
    in_valid = 1'b1;
    step();
    a = '{16'd1, 16'd0, 16'd1, 16'd0,  16'd0, 16'd1, 16'd0, 16'd1,
          16'd1, 16'd0, 16'd0, 16'd1,  16'd0, 16'd1, 16'd1, 16'd0};
    x = '{16'd5, 16'd10, 16'd20, 16'd10};
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_first_valid got %0b want 1", out_valid);
    end
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (y_o[r] !== exp1[r]) begin
        errors++; $display("FAIL b2b_first_y%0d got %0d want %0d", r + 1, y_o[r], exp1[r]);
      end
    end
    step();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_second_valid got %0b want 1", out_valid);
    end
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (y_o[r] !== exp2[r]) begin
        errors++; $display("FAIL b2b_second_y%0d got %0d want %0d", r + 1, y_o[r], exp2[r]);
      end
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_tail_valid got %0b want 0", out_valid);
    end
  endtask

  task automatic test_max_width();
    for (int i = 0; i < 16; i++) a[i] = 16'hFFFF;
    for (int i = 0; i < 4; i++) x[i] = 16'hFFFF;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL max_valid got %0b want 1", out_valid);
    end
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (y_o[r] !== 35'h3_FFF8_0004) begin
        errors++; $display("FAIL max_y%0d got %0h want 3fff80004", r + 1, y_o[r]);
      end
      checks++;
      if (y_o[r][34] !== 1'b0) begin
        errors++; $display("FAIL max_msb_y%0d got %0b want 0", r + 1, y_o[r][34]);
      end
    end
  endtask

  task automatic test_gap();
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < 16; i++) a[i] = N'($urandom);
      for (int i = 0; i < 4; i++) x[i] = N'($urandom);
      in_valid = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL gap_valid_c%0d got %0b want 0", c, out_valid);
      end
    end
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (y_o[r] !== 35'h3_FFF8_0004) begin
        errors++; $display("FAIL gap_hold_y%0d got %0h want 3fff80004", r + 1, y_o[r]);
      end
    end
  endtask

  task automatic test_reset_midflight();
    set_identity();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_valid got %0b want 0", out_valid);
    end
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (y_o[r] !== '0) begin
        errors++; $display("FAIL midrst_y%0d got %0h want 0", r + 1, y_o[r]);
      end
    end
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL midrst_release_valid_c%0d got %0b want 0", c, out_valid);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) a[i] = '0;
    for (int i = 0; i < 4; i++) x[i] = '0;
    test_reset();
    test_identity();
    test_anti_diag("anti");
    test_back_to_back();
    test_max_width();
    test_gap();
    test_reset_midflight();
    test_anti_diag("post_reset");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
